// File: rtl/bus_pkg.sv
// Shared types and defaults for the peripheral-bus initiator and the memory stage that feeds it.
// Keeps the state encoding and request layout in one place.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } bus_mst_state_t;

    // Request as produced by the memory stage.
    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter for one bus access: cleared before the access, counts HREADY-low cycles,
// flags the last permitted cycle and saturates instead of wrapping.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SAT   = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

    // High while the current WAIT cycle is the last one allowed without HREADY.
    assign expired = (count == LAST);

endmodule

// File: rtl/ahb_bus_master.sv
// Single-outstanding initiator: turns one valid/ready load/store into one bus access,
// with HREADY wait states, a timeout and misalignment errors reported as a one-cycle response.
module ahb_bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    bus_mst_state_t state;
    logic           tmo_clear;
    logic           tmo_enable;
    logic           tmo_expired;

    assign tmo_clear  = (state == ACCESS);
    assign tmo_enable = (state == WAIT) && !HREADY;

    bus_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .Rst    (Rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    assign req_ready = (state == IDLE);

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            HSEL       <= 1'b0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the entering transition raises them.
            HSEL       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!is_word_aligned(req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state  <= ACCESS;
                            HSEL   <= 1'b1;
                            HADDR  <= req_addr;
                            HWRITE <= req_write;
                            HWDATA <= req_wdata;
                        end
                    end
                end

                ACCESS: begin
                    state <= WAIT;
                end

                WAIT: begin
                    // A slave finishing on the last allowed cycle still wins over the timeout.
                    if (HREADY) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= HWRITE ? '0 : HRDATA;
                    end else if (tmo_expired) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
